// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: default operand/slice widths and
// the start/busy/done sequencer states used by the multi-cycle adder and
// subtractor.
package arith_pkg;

  localparam int unsigned ARITH_N = 32;
  localparam int unsigned ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub32_seq_fs_slice.sv
// W-bit combinational full subtractor: {bo, diff} = x - y - bi.
module fs_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  logic [W:0] full;

  // One extra bit catches the borrow as the sign of the widened difference.
  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  end

  assign diff = full[W-1:0];
  assign bo   = full[W];

endmodule

// File: rtl/sub32_seq.sv
// Multi-cycle N-bit subtractor: d = a - b - bin, one W-bit slice per clock,
// LSB slice first, borrow carried between slices in a register.
module sub32_seq
  import arith_pkg::*;
#(
  parameter int unsigned N = ARITH_N,
  parameter int unsigned W = ARITH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int unsigned K  = N / W;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  d_q;
  logic          borrow;
  logic          bout_q;

  logic [W-1:0]  x_slice;
  logic [W-1:0]  y_slice;
  logic [W-1:0]  diff_slice;
  logic          bo_slice;
  logic [N-1:0]  d_next;

  // Select the current operand slice and merge its difference into the result.
  always_comb begin
    x_slice = a_q[cnt*W +: W];
    y_slice = b_q[cnt*W +: W];
    d_next  = d_q;
    d_next[cnt*W +: W] = diff_slice;
  end

  fs_slice #(.W(W)) u_slice (
    .x    (x_slice),
    .y    (y_slice),
    .bi   (borrow),
    .diff (diff_slice),
    .bo   (bo_slice)
  );

  // Sequencer: accept in IDLE/DONE, walk slices in RUN, pulse DONE for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
            d_q    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          d_q    <= d_next;
          borrow <= bo_slice;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout_q <= bo_slice;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_sub32_seq.sv
// Scoreboard bench for sub32_seq: stimulus pushes expected results, a
// negedge monitor pops and checks them whenever done is presented.
module tb_sub32_seq;

  localparam int unsigned N = 32;
  localparam int unsigned W = 8;
  localparam int unsigned K = N / W;

  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    int unsigned  due;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;

  exp_t        q[$];
  int unsigned cyc;
  int unsigned busy_run;
  int unsigned n_tests;
  int unsigned n_fail;

  sub32_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("d", 64'(d), 64'(e.d));
        check("bout", 64'(bout), 64'(e.bout));
        check("latency", 64'(cyc), 64'(e.due));
        check("busy_cycles", 64'(busy_run), 64'(K));
      end
      busy_run = 0;
    end else if (!busy) begin
      busy_run = 0;
    end
  end

  // Drive a request and push the expectation once the accepting edge has passed.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                       input logic [N-1:0] ed, input logic eb, input bit hold);
    exp_t e;
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.d    = ed;
    e.bout = eb;
    e.due  = cyc + K;
    q.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      check("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rbi;
    logic [N:0]   wide;
    n_tests  = 0;
    n_fail   = 0;
    busy_run = 0;

    // Reset held with start high must not accept.
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    bin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_accept", 64'(busy), 64'd0);

    // Directed vectors.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0); drain();
    issue(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0); drain();
    issue(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); drain();
    issue(32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0); drain();
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b0); drain();
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0, 1'b0); drain();
    issue(32'h0000_0001, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0); drain();

    // start held through RUN while operands change: first latched set wins.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      a   = $urandom;
      b   = $urandom;
      bin = ~bin;
    end
    start = 1'b0;
    drain();

    // Back-to-back: second request lands in the DONE cycle of the first.
    issue(32'd100, 32'd30, 1'b0, 32'h0000_0046, 1'b0, 1'b0);
    repeat (K) @(posedge clk);
    #1;
    issue(32'd10, 32'd20, 1'b0, 32'hFFFF_FFF6, 1'b1, 1'b0);
    drain();

    // Reset on the second RUN edge abandons the operation.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    check("midrst_bout", 64'(bout), 64'd0);
    repeat (K + 3) @(posedge clk);
    #1;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0); drain();

    // Random operand sets against the unsigned borrow rule.
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbi  = 1'($urandom_range(1, 0));
      wide = {1'b0, rb} + {{N{1'b0}}, rbi};
      issue(ra, rb, rbi, ra - rb - {{(N-1){1'b0}}, rbi}, ({1'b0, ra} < wide), 1'b0);
      drain();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub32_seq.md
# sub32_seq

Multi-cycle 32-bit subtractor, the inverse of the team's 32-bit adder. It computes d = a − b − bin one W-bit slice per clock, least-significant slice first, with the borrow carried between slices in a register. It sits beside the adder in the arithmetic datapath and uses a start/busy/done handshake. Results from the two blocks can be cross-checked (a = d + b + bin).

## Interface
- N, default 32: operand/result width.
- W, default 8: slice width. N must be divisible by W. Cycles per operation K = N/W (4 by default).

- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request. Sampled only in IDLE or DONE.
- a, input, N: minuend. Captured on the accepting edge.
- b, input, N: subtrahend. Captured on the accepting edge.
- bin, input, 1: borrow-in. Captured on the accepting edge.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse when the result is valid.
- d, output, N: difference, (a − b − bin) mod 2^N.
- bout, output, 1: final borrow. 1 iff a < b + bin (unsigned).

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, d=0, bout=0. Internal slice counter, borrow and operand registers are all 0.
- IDLE with start=1: latch a, b and bin (bin initialises the borrow register). Set cnt=0 and go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - Compute {borrow, diff} = a[cnt] − b[cnt] − borrow for the W-bit slice cnt.
  - Write diff into d bits [cnt*W +: W]. Other slices are unchanged.
  - Increment cnt.
  - On the edge that processes slice K−1, load bout with the final borrow and go to DONE.
- d is cleared to 0 on accept. Partial slices are visible while busy, but only the value present while done=1 is defined as the result.
- start during RUN is ignored. Latched operands are not disturbed, and a, b, bin may change freely.
- DONE lasts exactly one cycle with done=1.
  - start=1 in that cycle: accept new operands, go to RUN. This is back-to-back operation.
  - start=0: go to IDLE.
- d and bout hold their values in IDLE until the next accept.
- Arithmetic is unsigned, modulo 2^N. The borrow is 1 bit and propagates across slice boundaries only through the registered borrow.

## Timing
- Latency: start sampled high at edge E0 → busy=1 after E0 → done=1 and d/bout valid after edge E0+K. Default: 4 cycles.
- busy is high for exactly K cycles, deasserted in the same edge that raises done.
- Throughput with back-to-back starts: one result every K+1 cycles.
- rst=1 at any edge, including mid-RUN or DONE, forces IDLE with all outputs at reset values on that edge. The operation is abandoned and no done is produced. rst has priority over start.
- start and rst both high: rst wins, no accept.

## Structure
- Shared package arith_pkg holds:
  - state enum: IDLE, RUN, DONE.
  - default N and W constants, shared with the adder.
- Natural sub-module: fs_slice. It is a purely combinational W-bit full subtractor with ports x, y, bi in; diff, bo out. sub32_seq instantiates it once.
- Top-level logic: FSM, slice counter (width clog2(K)), operand registers, borrow register, result register.

## Test plan
- Reset: hold rst for 3 cycles with start=1 → busy=0, done=0, d=0x00000000, bout=0 and no accept.
- Basic: a=0x00000005, b=0x00000003, bin=0 → after exactly 4 cycles done=1, d=0x00000002, bout=0. busy is high for 4 cycles.
- Full borrow chain: a=0x00000000, b=0x00000001, bin=0 → d=0xFFFFFFFF, bout=1. Also a=0x00000000, b=0x00000000, bin=1 → d=0xFFFFFFFF, bout=1.
- Slice boundary: a=0x00000100, b=0x00000000, bin=1 → d=0x000000FF, bout=0. Then a=0x80000000, b=0x7FFFFFFF → d=0x00000001, bout=0.
- Handshake:
  - start held high through RUN with a and b changing → the result still matches the first latched operands.
  - start=1 in the DONE cycle with a=10, b=20 → second done 4 cycles later, d=0xFFFFFFF6, bout=1.
- Reset mid-op: accept a=0xFFFFFFFF, b=1, then assert rst on the second RUN edge → IDLE, d=0, no done pulse. A fresh start then completes normally. Finish with 1000 random operand sets checked against a − b − bin and the bout rule.
